btn_debounce_n: RTL and testbench
=================================

# btn_debounce_n

Parametrised multi-channel push-button conditioner for board-level inputs. Each channel synchronises a raw asynchronous button with an N-stage flop chain. It then applies counter-based stability filtering: the output only changes after the synchronised input has held a new level for a programmable number of clocks. Alongside the clean level, each channel produces one-cycle press/release strobes and a press-toggled level. The block sits between the FPGA button pins and the counter/voting control logic.

## Interface
- `N_CH`, 4, number of independent button channels (≥1)
- `SYNC_STAGES`, 3, synchroniser flop count per channel (≥2)
- `STABLE_CNT`, 1000000, consecutive clocks a new level must persist before acceptance (≥1; 10 ms at 100 MHz)
- `CNT_W`, clog2(STABLE_CNT) with minimum 1, derived, counter width; not overridden by users

- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `btn_in`  input  N_CH  raw button levels, asynchronous to clk, active-high
- `btn_out`  output  N_CH  debounced level per channel
- `btn_rise`  output  N_CH  one-cycle strobe on each accepted 0→1 of btn_out
- `btn_fall`  output  N_CH  one-cycle strobe on each accepted 1→0 of btn_out
- `btn_toggle`  output  N_CH  level that inverts on every btn_rise

## Operation
- Channels are fully independent, with no shared state. Per channel:
  - `SYNC_STAGES` flops in series form the synchroniser. Call the last stage `sync`.
  - A `CNT_W`-bit stability counter `cnt` filters `sync`.
- Filter rules, evaluated each edge:
  - `sync == btn_out`: `cnt` ← 0.
  - `sync != btn_out` and `cnt < STABLE_CNT-1`: `cnt` ← `cnt`+1.
  - `sync != btn_out` and `cnt == STABLE_CNT-1`: `btn_out` ← `sync` and `cnt` ← 0. On the same edge, `btn_rise` or `btn_fall` ← 1 per the direction.
- Any return of `sync` to `btn_out` before acceptance clears `cnt`. Bounce shorter than `STABLE_CNT` consecutive clocks is fully rejected.
- Strobes are registered and high for exactly one clock, then return to 0. `btn_rise` and `btn_fall` are never high together on one channel.
- `btn_toggle` inverts on the same edge that raises `btn_rise`. `btn_fall` does not affect it.
- `cnt` saturates by construction: it never exceeds `STABLE_CNT-1` and never wraps.
- `STABLE_CNT == 1` (CNT_W = 1): a mismatch is accepted on its first edge, leaving a pure synchroniser plus edge detection.

## Timing
- Reset (`rst` high, asynchronous assert) clears all of the following to 0: synchroniser flops, `cnt`, `btn_out`, `btn_rise`, `btn_fall`, `btn_toggle`.
- Leaving reset: the design is used with synchronous de-assertion upstream. If `btn_in` is held high through reset, the channel produces a normal `btn_rise` after full latency. This is intended.
- Reset mid-count: `cnt` is discarded; filtering restarts from 0 after release.
- Latency: `btn_in` changes before edge k and stays constant. `sync` differs after edge k+SYNC_STAGES-1, and `btn_out` plus the strobe update on edge k+SYNC_STAGES+STABLE_CNT-1. This is `SYNC_STAGES+STABLE_CNT` edges inclusive of k.
- Strobe and level change are coincident (same edge). There is no combinational path from `btn_in` to any output.
- Minimum accepted press-to-release spacing: `STABLE_CNT` clocks.

## Test plan
Parameters for all tests: N_CH=2, SYNC_STAGES=3, STABLE_CNT=8.
- Clean press: ch0 0→1 before edge 0, held → `btn_out[0]`=1, `btn_rise[0]`=1 only at edge 10, `btn_toggle[0]`=1 from edge 10. Release → `btn_fall[0]` pulse exactly 11 edges after the change.
- Bounce reject: ch0 high for 7 clocks, low 2, high again and held → no output change during the 7-clock pulse. `btn_out[0]` rises 11 edges after the final rising transition.
- Glitch-only: ch1 high 5 clocks, then low → `btn_out[1]`, `btn_rise[1]` and `btn_toggle[1]` stay 0 throughout.
- Independence: ch0 and ch1 pressed 3 clocks apart → each rises exactly at its own edge+10. Strobes never interact.
- Toggle: three clean presses on ch0 → `btn_toggle[0]` goes 1, 0, 1. It does not change on any `btn_fall`.
- Async reset: assert `rst` mid-edge while `cnt`=5 with `btn_out[0]`=1 → all outputs 0 immediately, not waiting for clk. After release with `btn_in[0]` held high → `btn_rise[0]` at release+11 edges.

Source files
------------

// File: rtl/btn_debounce_n.sv
// Multi-channel push-button conditioner: per-channel synchroniser, counter-based
// stability filter, registered press/release strobes and a press-toggled level.
module btn_debounce_n #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 3,
  parameter int STABLE_CNT  = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_toggle
);

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   tog_q, tog_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[ch]};
      end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; reaching CNT_MAX accepts it and fires the matching strobe.
    always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      tog_d  = tog_q;
      if (sync_bit == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        out_d  = sync_bit;
        rise_d = sync_bit;
        fall_d = ~sync_bit;
        tog_d  = tog_q ^ sync_bit;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        tog_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        tog_q  <= tog_d;
      end
    end

    assign btn_out[ch]    = out_q;
    assign btn_rise[ch]   = rise_q;
    assign btn_fall[ch]   = fall_q;
    assign btn_toggle[ch] = tog_q;
  end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Self-checking bench for btn_debounce_n: hand-derived vector table, bounce and
// reset sequences, then random button activity against a window-based model.
module tb_btn_debounce_n;

  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 3;
  localparam int STABLE_CNT  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btnIn;
  logic [1:0] btnOut, btnRise, btnFall, btnToggle;

  int errors = 0;
  int checks = 0;

  btn_debounce_n #(
    .N_CH(N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btnIn),
    .btn_out(btnOut),
    .btn_rise(btnRise),
    .btn_fall(btnFall),
    .btn_toggle(btnToggle)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronised input (the raw
  // input delayed by SYNC_STAGES edges) has disagreed with the current output
  // for the last STABLE_CNT edges in a row.
  bit         hist [2][$];
  logic [1:0] mOut, mRise, mFall, mTog;

  task automatic modelReset();
    for (int c = 0; c < N_CH; c++) begin
      hist[c].delete();
      for (int i = 0; i < SYNC_STAGES + STABLE_CNT + 1; i++) hist[c].push_back(1'b0);
    end
    mOut = '0; mRise = '0; mFall = '0; mTog = '0;
  endtask

  task automatic modelEdge(input logic [1:0] b);
    bit allDiff;
    int sz;
    for (int c = 0; c < N_CH; c++) begin
      hist[c].push_back(b[c]);
      if (hist[c].size() > 40) void'(hist[c].pop_front());
      sz = hist[c].size();
      allDiff = 1'b1;
      for (int j = 0; j < STABLE_CNT; j++)
        if (hist[c][sz-1-SYNC_STAGES-j] == mOut[c]) allDiff = 1'b0;
      mRise[c] = allDiff && !mOut[c];
      mFall[c] = allDiff && mOut[c];
      if (allDiff) mOut[c] = ~mOut[c];
      if (mRise[c]) mTog[c] = ~mTog[c];
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given raw inputs; outputs compared against the model.
  task automatic applyStimulus(input logic [1:0] b);
    btnIn = b;
    @(posedge clk);
    modelEdge(b);
    #1;
    checkOutput("model_out", btnOut, mOut);
    checkOutput("model_rise", btnRise, mRise);
    checkOutput("model_fall", btnFall, mFall);
    checkOutput("model_toggle", btnToggle, mTog);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic asyncReset(input logic [1:0] holdIn);
    btnIn = holdIn;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out", btnOut, 2'b00);
    checkOutput("rst_rise", btnRise, 2'b00);
    checkOutput("rst_fall", btnFall, 2'b00);
    checkOutput("rst_toggle", btnToggle, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    logic [1:0] btn;
    int         hold;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] tog;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0] lvl;
    logic [1:0] b;

    // clean press/release ch0
    vecs.push_back('{2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vecs.push_back('{2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b00, 10, 2'b01, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b01});
    vecs.push_back('{2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b01});
    // glitch-only ch1
    vecs.push_back('{2'b10,  5, 2'b00, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b00, 20, 2'b00, 2'b00, 2'b00, 2'b01});
    // independence: ch1 pressed three clocks after ch0
    vecs.push_back('{2'b01,  3, 2'b00, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b11,  7, 2'b00, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b11,  1, 2'b01, 2'b01, 2'b00, 2'b00});
    vecs.push_back('{2'b11,  2, 2'b01, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b11,  1, 2'b11, 2'b10, 2'b00, 2'b10});
    vecs.push_back('{2'b11,  1, 2'b11, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{2'b00, 10, 2'b11, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{2'b00,  1, 2'b00, 2'b00, 2'b11, 2'b10});
    vecs.push_back('{2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b10});
    // third press on ch0; toggle ignores the release
    vecs.push_back('{2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b11});
    vecs.push_back('{2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b11});
    vecs.push_back('{2'b00, 10, 2'b01, 2'b00, 2'b00, 2'b11});
    vecs.push_back('{2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b11});

    rst   = 1'b1;
    btnIn = 2'b00;
    modelReset();
    #2;
    checkOutput("init_out", btnOut, 2'b00);
    checkOutput("init_rise", btnRise, 2'b00);
    checkOutput("init_fall", btnFall, 2'b00);
    checkOutput("init_toggle", btnToggle, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[v]) begin
      for (int h = 0; h < vecs[v].hold; h++) applyStimulus(vecs[v].btn);
      checkOutput($sformatf("vec%0d_out", v), btnOut, vecs[v].out);
      checkOutput($sformatf("vec%0d_rise", v), btnRise, vecs[v].rise);
      checkOutput($sformatf("vec%0d_fall", v), btnFall, vecs[v].fall);
      checkOutput($sformatf("vec%0d_toggle", v), btnToggle, vecs[v].tog);
    end

    // bounce: 7 high, 2 low, then held high; only the final run is accepted
    for (int i = 0; i < 30; i++) begin
      b = (i < 7 || i >= 9) ? 2'b01 : 2'b00;
      applyStimulus(b);
      checkOutput($sformatf("bounce%0d_out", i), btnOut, (i >= 19) ? 2'b01 : 2'b00);
      checkOutput($sformatf("bounce%0d_rise", i), btnRise, (i == 19) ? 2'b01 : 2'b00);
      checkOutput($sformatf("bounce%0d_toggle", i), btnToggle, (i >= 19) ? 2'b10 : 2'b11);
    end

    // release ch0 and reset after five counts, then hold ch0 high through reset
    for (int i = 0; i < 8; i++) applyStimulus(2'b00);
    checkOutput("prereset_out", btnOut, 2'b01);
    asyncReset(2'b01);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(2'b01);
      checkOutput($sformatf("postrst%0d_rise", i), btnRise, (i == 10) ? 2'b01 : 2'b00);
      checkOutput($sformatf("postrst%0d_out", i), btnOut, (i >= 10) ? 2'b01 : 2'b00);
    end

    // random button activity with run lengths around the filter threshold
    lvl = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 9) == 0) lvl[c] = ~lvl[c];
      applyStimulus(lvl);
      if (n == 700) asyncReset(lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
